// File: rtl/dcpu16_pkg.sv
// dcpu16_pkg: shared phase encoding and decode constants for the DCPU-16 sequencer
package dcpu16_pkg;
  typedef enum logic [1:0] {PH_0, PH_1, PH_2, PH_3} phase_t;
  localparam int A_PC = 'h1C;
  localparam int JSR_OP = 'h01;
  localparam logic [1:0] COND_PFX = 2'b11;
endpackage

// File: rtl/dcpu16_phase.sv
// dcpu16_phase: 0..3 phase counter that stalls at phase 2 until f_ack; in clk rst_n ena f_ack, out pha stl adv
module dcpu16_phase
  import dcpu16_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   ena,
  input  logic   f_ack,
  output phase_t pha,
  output logic   stl,
  output logic   adv
);
  phase_t pha_q, pha_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pha_q <= PH_0;
    else pha_q <= pha_d;
  always_comb begin
    stl = pha_q == PH_2 && !f_ack;
    adv = ena && !stl;
    pha_d = adv ? phase_t'(pha_q + 2'd1) : pha_q;
  end
  assign pha = pha_q;
endmodule

// File: rtl/dcpu16_seq.sv
// dcpu16_seq: DCPU-16 fetch/decode sequencer; fetch bus f_dti/f_ack, CC/wpc in; ireg opc pha rra rwa rwe bra jsr fwd stl out
module dcpu16_seq
  import dcpu16_pkg::*;
#(
  parameter int DW = 16,
  parameter int OW = 4,
  parameter int FW = 6,
  parameter int RW = 3,
  parameter logic [DW-1:0] NOP = DW'(1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [DW-1:0] f_dti,
  input  logic          f_ack,
  input  logic          CC,
  input  logic          wpc,
  output logic [DW-1:0] ireg,
  output logic [1:0]    pha,
  output logic [OW-1:0] opc,
  output logic [RW-1:0] rra,
  output logic [RW-1:0] rwa,
  output logic          rwe,
  output logic          bra,
  output logic          jsr,
  output logic          fwd,
  output logic          stl
);
  phase_t ph;
  logic adv;
  logic [DW-1:0] ireg_q, ireg_d;
  logic [OW-1:0] opc_q, opc_d;
  logic [RW-1:0] rra_q, rra_d, rwa_q, rwa_d, pend_rwa_q, pend_rwa_d;
  logic pend_rwe_q, pend_rwe_d, skip_q, skip_d, fwd_q, fwd_d;
  logic rwe_q, rwe_d, bra_q, bra_d, jsr_q, jsr_d;
  logic [FW-1:0] dec_a;
  logic [RW-1:0] b_lo;
  logic op_z, cond;
  dcpu16_phase u_phase (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .f_ack(f_ack),
    .pha  (ph),
    .stl  (stl),
    .adv  (adv)
  );
  assign dec_a = ireg_q[OW+FW-1:OW];
  assign b_lo = ireg_q[OW+FW+RW-1:OW+FW];
  assign op_z = ireg_q[OW-1:0] == '0;
  assign cond = opc_q[OW-1 -: 2] == COND_PFX;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ireg_q <= '0;
      opc_q <= '0;
      rra_q <= '0;
      rwa_q <= '0;
      pend_rwa_q <= '0;
      pend_rwe_q <= 1'b0;
      skip_q <= 1'b0;
      fwd_q <= 1'b0;
      rwe_q <= 1'b0;
      bra_q <= 1'b0;
      jsr_q <= 1'b0;
    end else begin
      ireg_q <= ireg_d;
      opc_q <= opc_d;
      rra_q <= rra_d;
      rwa_q <= rwa_d;
      pend_rwa_q <= pend_rwa_d;
      pend_rwe_q <= pend_rwe_d;
      skip_q <= skip_d;
      fwd_q <= fwd_d;
      rwe_q <= rwe_d;
      bra_q <= bra_d;
      jsr_q <= jsr_d;
    end
  always_comb begin
    ireg_d = ireg_q;
    opc_d = opc_q;
    rra_d = rra_q;
    rwa_d = rwa_q;
    pend_rwa_d = pend_rwa_q;
    pend_rwe_d = pend_rwe_q;
    skip_d = skip_q;
    fwd_d = fwd_q;
    // pulses drop on any enabled cycle, including a fetch stall
    rwe_d = ena ? (ph == PH_1 && pend_rwe_q && CC && !cond) : rwe_q;
    bra_d = ena ? (ph == PH_0 && dec_a == FW'(A_PC)) : bra_q;
    jsr_d = ena ? (ph == PH_0 && op_z && dec_a == FW'(JSR_OP)) : jsr_q;
    if (adv) begin
      rra_d = (ph == PH_1 || ph == PH_3) ? dec_a[RW-1:0] : b_lo;
      fwd_d = rra_d == rwa_q && (rwe_q || pend_rwe_q);
      if (ph == PH_0) begin
        pend_rwa_d = dec_a[RW-1:0];
        pend_rwe_d = dec_a[FW-1:RW] == '0 && !op_z;
        skip_d = cond && !CC;
      end
      if (ph == PH_1) rwa_d = pend_rwa_q;
      if (ph == PH_2) begin
        ireg_d = (wpc || skip_q) ? NOP : f_dti;
        opc_d = ireg_q[OW-1:0];
        skip_d = 1'b0;
      end
    end
  end
  assign ireg = ireg_q;
  assign opc = opc_q;
  assign pha = ph;
  assign rra = rra_q;
  assign rwa = rwa_q;
  assign rwe = rwe_q;
  assign bra = bra_q;
  assign jsr = jsr_q;
  assign fwd = fwd_q;
endmodule

// File: tb/tb_dcpu16_seq.sv
// tb_dcpu16_seq: directed and randomized check of dcpu16_seq against a behavioural model
module tb_dcpu16_seq;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, f_ack = 1'b1, CC = 1'b1, wpc = 1'b0;
  logic [15:0] f_dti = 16'h0;
  logic [15:0] ireg;
  logic [1:0] pha;
  logic [3:0] opc;
  logic [2:0] rra, rwa;
  logic rwe, bra, jsr, fwd, stl;
  int checks = 0, errors = 0;
  int m_ireg, m_pha, m_opc, m_rra, m_rwa, p_rwa;
  bit m_rwe, m_bra, m_jsr, m_fwd, m_skip, p_rwe;
  logic [15:0] tbl [8] = '{16'h7C01, 16'h0010, 16'h7DC1, 16'h000C, 16'h000D, 16'h0001, 16'h0C01, 16'h7C0F};
  always #5 clk = ~clk;
  dcpu16_seq dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .f_dti(f_dti), .f_ack(f_ack), .CC(CC), .wpc(wpc),
    .ireg(ireg), .pha(pha), .opc(opc), .rra(rra), .rwa(rwa), .rwe(rwe), .bra(bra),
    .jsr(jsr), .fwd(fwd), .stl(stl)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_ireg = 0; m_pha = 0; m_opc = 0; m_rra = 0; m_rwa = 0; p_rwa = 0;
    m_rwe = 0; m_bra = 0; m_jsr = 0; m_fwd = 0; m_skip = 0; p_rwe = 0;
  endtask
  task automatic model_step();
    int a, b, op, nrra;
    bit adv, cond, nb, nj, nw;
    a = (m_ireg / 16) % 64;
    b = (m_ireg / 1024) % 64;
    op = m_ireg % 16;
    cond = m_opc / 4 == 3;
    adv = !(m_pha == 2 && !f_ack);
    nb = m_pha == 0 && a == 28;
    nj = m_pha == 0 && op == 0 && a == 1;
    nw = m_pha == 1 && p_rwe && CC && !cond;
    if (adv) begin
      nrra = (m_pha % 2 == 1) ? a % 8 : b % 8;
      m_fwd = nrra == m_rwa && (m_rwe || p_rwe);
      m_rra = nrra;
      if (m_pha == 0) begin
        p_rwa = a % 8;
        p_rwe = a < 8 && op != 0;
        m_skip = cond && !CC;
      end else if (m_pha == 1) m_rwa = p_rwa;
      else if (m_pha == 2) begin
        m_opc = op;
        m_ireg = (wpc || m_skip) ? 1 : int'(f_dti);
        m_skip = 0;
      end
      m_pha = (m_pha + 1) % 4;
    end
    m_bra = nb; m_jsr = nj; m_rwe = nw;
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) model_reset();
    else if (ena) model_step();
  always @(negedge clk) begin
    chk("ireg", 32'(ireg), m_ireg);
    chk("pha", 32'(pha), m_pha);
    chk("opc", 32'(opc), m_opc);
    chk("rra", 32'(rra), m_rra);
    chk("rwa", 32'(rwa), m_rwa);
    chk("rwe", 32'(rwe), 32'(m_rwe));
    chk("bra", 32'(bra), 32'(m_bra));
    chk("jsr", 32'(jsr), 32'(m_jsr));
    chk("fwd", 32'(fwd), 32'(m_fwd));
    chk("stl", 32'(stl), 32'(m_pha == 2 && !f_ack));
  end
  task automatic cyc(input logic [15:0] d, input logic a, input logic c, input logic w);
    f_dti = d; f_ack = a; CC = c; wpc = w;
    @(posedge clk);
    #1;
  endtask
  task automatic adv_to(input int p, input logic c);
    for (int i = 0; i < 6 && m_pha != p; i++) cyc(16'h0, 1'b1, c, 1'b0);
    chk("reach_pha", 32'(pha), 32'(p));
  endtask
  task automatic fetch(input logic [15:0] w, input logic c, input logic wp);
    adv_to(2, c);
    cyc(w, 1'b1, c, wp);
  endtask
  task automatic all_zero(input string n);
    chk({n, "_ireg"}, 32'(ireg), 0);
    chk({n, "_pha"}, 32'(pha), 0);
    chk({n, "_opc"}, 32'(opc), 0);
    chk({n, "_rra"}, 32'(rra), 0);
    chk({n, "_rwa"}, 32'(rwa), 0);
    chk({n, "_pulses"}, 32'({rwe, bra, jsr, fwd, stl}), 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    all_zero("reset");
    rst_n = 1'b1;
    cyc(16'h0, 1'b1, 1'b1, 1'b0);
    chk("seq_pha1", 32'(pha), 1);
    cyc(16'h0, 1'b1, 1'b1, 1'b0);
    chk("seq_pha2", 32'(pha), 2);
    repeat (3) begin
      cyc(16'h7C01, 1'b0, 1'b1, 1'b0);
      chk("stall_stl", 32'(stl), 1);
      chk("stall_pha", 32'(pha), 2);
      chk("stall_ireg", 32'(ireg), 0);
    end
    cyc(16'h7C01, 1'b1, 1'b1, 1'b0);
    chk("load_ireg", 32'(ireg), 32'h7C01);
    chk("load_pha", 32'(pha), 3);
    chk("load_stl", 32'(stl), 0);
    adv_to(1, 1'b1);
    adv_to(2, 1'b1);
    chk("set_rwe", 32'(rwe), 1);
    chk("set_rwa", 32'(rwa), 0);
    chk("set_fwd", 32'(fwd), 1);
    fetch(16'h0010, 1'b1, 1'b0);
    chk("rwe_one_cycle", 32'(rwe), 0);
    chk("opc_set", 32'(opc), 1);
    adv_to(1, 1'b1);
    chk("jsr_pulse", 32'(jsr), 1);
    adv_to(2, 1'b1);
    chk("jsr_end", 32'(jsr), 0);
    chk("jsr_no_rwe", 32'(rwe), 0);
    fetch(16'h7DC1, 1'b1, 1'b0);
    adv_to(1, 1'b1);
    chk("bra_pulse", 32'(bra), 1);
    adv_to(2, 1'b1);
    chk("bra_end", 32'(bra), 0);
    fetch(16'h000C, 1'b1, 1'b0);
    fetch(16'h7C01, 1'b1, 1'b0);
    chk("ife_opc", 32'(opc), 32'hC);
    adv_to(2, 1'b0);
    chk("cc0_no_rwe", 32'(rwe), 0);
    fetch(16'h1234, 1'b1, 1'b0);
    chk("skip_nop", 32'(ireg), 1);
    fetch(16'h5678, 1'b1, 1'b0);
    chk("after_skip", 32'(ireg), 32'h5678);
    fetch(16'hABCD, 1'b1, 1'b1);
    chk("wpc_nop", 32'(ireg), 1);
    fetch(16'h4321, 1'b1, 1'b0);
    chk("after_wpc", 32'(ireg), 32'h4321);
    adv_to(2, 1'b1);
    cyc(16'h0, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_stl", 32'(stl), 1);
    #2 rst_n = 1'b0;
    #1;
    all_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(16'h0, 1'b1, 1'b1, 1'b0);
    cyc(16'h0, 1'b1, 1'b1, 1'b0);
    cyc(16'h2222, 1'b1, 1'b1, 1'b0);
    chk("refetch_ireg", 32'(ireg), 32'h2222);
    chk("refetch_pha", 32'(pha), 3);
    for (int i = 0; i < 4000; i++) begin
      rst_n = $urandom_range(0, 499) != 0;
      ena = $urandom_range(0, 9) != 0;
      f_ack = $urandom_range(0, 3) != 0;
      CC = 1'($urandom_range(0, 1));
      wpc = $urandom_range(0, 7) == 0;
      f_dti = $urandom_range(0, 2) == 0 ? tbl[$urandom_range(0, 7)] : 16'($urandom);
      @(posedge clk);
      #1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
